// File: rtl/acc_mult_seq_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
//   state_t   : sequencer states (idle, accumulator clear, iterate, done)
//   DEF_W     : default data path width
//   cnt_width : iteration counter width derived from the data path width
package acc_mult_seq_pkg;

  localparam int unsigned DEF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ITER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One extra bit over log2(W) so the counter can represent W itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return 32'($clog2(w)) + 32'd1;
  endfunction

endpackage

// File: rtl/acc_mult_dp.sv
// Operand shift registers and iteration counter for acc_mult_seq.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_load             : capture i_op_a/i_op_b and clear the counter
//   i_shift            : advance one iteration (mcand <<1, mplier >>1, count+1)
//   i_op_a, i_op_b     : multiplicand / multiplier to capture
//   o_mcand            : current shifted multiplicand
//   o_mplier_lsb       : two low multiplier bits (current and next iteration)
//   o_last             : counter is on the final iteration
module acc_mult_dp
  import acc_mult_seq_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  output logic [W-1:0] o_mcand,
  output logic [1:0]   o_mplier_lsb,
  output logic         o_last
);

  localparam int unsigned CW = cnt_width(W);

  logic [W-1:0]  r_mcand;
  logic [W-1:0]  r_mplier;
  logic [CW-1:0] r_count;

  // Load has priority; the FSM never asserts both in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_mcand  <= i_op_a;
      r_mplier <= i_op_b;
      r_count  <= '0;
    end else if (i_shift) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end

  assign o_mcand      = r_mcand;
  assign o_mplier_lsb = r_mplier[1:0];
  assign o_last       = (r_count == CW'(W - 1));

endmodule

// File: rtl/acc_mult_seq.sv
// Sequencer that drives a shared W-bit accumulator to form the low W bits
// of an unsigned W x W product by shift-and-add, with fixed latency.
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset (shared with accumulator)
//   Start        : request a multiply; only honoured in idle
//   OpA, OpB     : multiplicand / multiplier, captured when Start is accepted
//   AccIn        : accumulator read-back (DataOut)
//   AccWriteEn   : accumulator WriteEn
//   AccDataOut   : accumulator DataIn
//   Busy         : operation in progress (clear + iterate)
//   Done         : one-cycle completion pulse
//   Result       : registered product, held until the next completion
module acc_mult_seq
  import acc_mult_seq_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] OpA,
  input  logic [W-1:0] OpB,
  input  logic [W-1:0] AccIn,
  output logic         AccWriteEn,
  output logic [W-1:0] AccDataOut,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Result
);

  state_t       r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_acc_wen;
  logic [W-1:0] r_result;

  logic         w_load;
  logic         w_shift;
  logic [W-1:0] w_mcand;
  logic [1:0]   w_mplier_lsb;
  logic         w_last;
  logic [W-1:0] w_sum;

  assign w_load  = (r_state == ST_IDLE) && Start;
  assign w_shift = (r_state == ST_ITER);

  acc_mult_dp #(
    .W (W)
  ) u_dp (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_load       (w_load),
    .i_shift      (w_shift),
    .i_op_a       (OpA),
    .i_op_b       (OpB),
    .o_mcand      (w_mcand),
    .o_mplier_lsb (w_mplier_lsb),
    .o_last       (w_last)
  );

  // Partial-product add; carry out of the top bit is dropped.
  assign w_sum = AccIn + w_mcand;

  // FSM with registered status outputs. The write enable is precomputed one
  // cycle ahead from the multiplier bit that the next cycle will consume.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_acc_wen <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_acc_wen <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state   <= ST_ITER;
          r_acc_wen <= w_mplier_lsb[0];
        end
        ST_ITER: begin
          if (w_last) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_acc_wen <= 1'b0;
            r_result  <= w_mplier_lsb[0] ? w_sum : AccIn;
          end else begin
            r_acc_wen <= w_mplier_lsb[1];
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_acc_wen <= 1'b0;
        end
      endcase
    end
  end

  // A reset arriving mid-operation must not let a write slip through.
  assign AccWriteEn = r_acc_wen && !Reset;
  assign AccDataOut = (r_state == ST_ITER) ? w_sum : '0;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Result     = r_result;

endmodule

// File: tb/tb_acc_mult_seq.sv
// Self-checking bench for acc_mult_seq with a behavioural accumulator.
module tb_acc_mult_seq;

  localparam int W = 8;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic [W-1:0] AccIn;
  logic         AccWriteEn;
  logic [W-1:0] AccDataOut;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;

  logic [W-1:0] acc;
  int           cyc;
  int           checks;
  int           errors;
  int           last_start;

  typedef struct {
    logic [W-1:0] res;
    int           wens;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];

  acc_mult_seq #(.W(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .OpA        (OpA),
    .OpB        (OpB),
    .AccIn      (AccIn),
    .AccWriteEn (AccWriteEn),
    .AccDataOut (AccDataOut),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Shared accumulator: same clock and reset net as the sequencer.
  always @(posedge Clk) begin
    if (Reset) acc <= '0;
    else if (AccWriteEn) acc <= AccDataOut;
  end
  assign AccIn = acc;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every Done and checks per-cycle invariants.
  initial begin : monitor
    logic [W-1:0] last_result;
    int           busy_run;
    int           wen_run;
    exp_t         e;
    last_result = '0;
    busy_run    = 0;
    wen_run     = 0;
    forever begin
      @(negedge Clk);
      #1;
      if (Reset) begin
        busy_run    = 0;
        wen_run     = 0;
        last_result = '0;
      end else begin
        if (Busy) busy_run++;
        if (AccWriteEn) wen_run++;
        check("busy_done_exclusive", int'(Busy && Done), 0);
        check("wen_outside_busy", int'(AccWriteEn && !Busy), 0);
        if (Done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("result", int'(Result), int'(e.res));
            check("acc_final", int'(acc), int'(e.res));
            check("wen_count", wen_run, e.wens);
            check("busy_cycles", busy_run, W + 1);
            last_result = e.res;
          end
          busy_run = 0;
          wen_run  = 0;
        end else begin
          check("result_hold", int'(Result), int'(last_result));
        end
      end
    end
  end

  // Wait until a negedge where the sequencer is idle (neither busy nor done).
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((Busy || Done) && n < 64);
    if (n >= 64) check("idle_timeout", 1, 0);
  endtask

  // Issue one multiply; reference is plain integer multiplication.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit noise, input bit hold);
    logic [2*W-1:0] p;
    exp_t           e;
    int             n;
    wait_idle();
    Start      = 1'b1;
    OpA        = a;
    OpB        = b;
    last_start = cyc;
    p          = (2*W)'(a) * (2*W)'(b);
    e.res      = p[W-1:0];
    e.wens     = 1 + $countones(b);
    e.done_cyc = cyc + W + 2;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (!hold) begin
        if (noise && Busy) begin
          Start = 1'($urandom_range(0, 1));
          OpA   = W'($urandom);
          OpB   = W'($urandom);
        end else begin
          Start = 1'b0;
        end
      end
    end while (!Done && n < 32);
    if (n >= 32) check("done_timeout", 1, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int s0;
    int s1;
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    Start  = 1'b0;
    OpA    = '0;
    OpB    = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_result", int'(Result), 0);
    check("rst_wen", int'(AccWriteEn), 0);
    check("rst_dataout", int'(AccDataOut), 0);
    check("rst_acc", int'(acc), 0);

    do_op(8'd13, 8'd11, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    do_op(8'h10, 8'h10, 1'b0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 1'b0);
    do_op(8'h37, 8'h00, 1'b0, 1'b0);

    // Start held high: re-acceptance every W+3 cycles.
    do_op(8'd2, 8'd3, 1'b0, 1'b1);
    s0 = last_start;
    do_op(8'd2, 8'd3, 1'b0, 1'b1);
    s1 = last_start;
    check("b2b_period", s1 - s0, W + 3);
    do_op(8'd2, 8'd3, 1'b0, 1'b1);
    check("b2b_period", last_start - s1, W + 3);
    Start = 1'b0;

    // Inputs thrash during the operation.
    do_op(8'd2, 8'd3, 1'b1, 1'b0);
    do_op(8'hA5, 8'h3C, 1'b1, 1'b0);

    // Reset during the fifth iterate cycle aborts the operation.
    wait_idle();
    Start = 1'b1;
    OpA   = 8'h5A;
    OpB   = 8'hC3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("abort_busy", int'(Busy), 0);
    check("abort_done", int'(Done), 0);
    check("abort_result", int'(Result), 0);
    check("abort_acc", int'(acc), 0);
    check("abort_wen", int'(AccWriteEn), 0);
    do_op(8'd7, 8'd9, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    wait_idle();
    repeat (3) @(negedge Clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
